// File: rtl/mos6502_timing.sv
// T-state sequencer and interrupt front end for the 6502 core: walks T0..T5/SD1/SD2,
// synchronises nIRQ/nNMI/nRES, and forces BRK into IR when an interrupt or reset is taken.
module mos6502_timing #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [7:0]  BRK_OPCODE  = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       READY,
  input  logic       RnW,
  input  logic       NEXT_T,
  input  logic       CLEAR_T,
  input  logic       BRK,
  input  logic       PSR_I,
  input  logic       nIRQ,
  input  logic       nNMI,
  input  logic       nRES,
  input  logic [7:0] DIR,
  output logic [5:0] T_state,
  output logic       SD2,
  output logic [7:0] IR,
  output logic       nNMI_req,
  output logic       nIRQ_req,
  output logic       nRESET_req,
  output logic       HW_INT,
  output logic       SYNC
);

  typedef enum logic [2:0] {
    ST_T0, ST_T1, ST_T2, ST_T3, ST_T4, ST_T5, ST_SD1, ST_SD2
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  ir_q, ir_d;
  logic        hw_int_q, hw_int_d;
  logic        nnmi_req_q, nnmi_req_d;
  logic        nirq_req_q, nirq_req_d;
  logic        nres_req_q, nres_req_d;
  logic        nmi_prev_q, nmi_prev_d;

  // Pin synchronisers; bit 2 = nRES, bit 1 = nNMI, bit 0 = nIRQ
  logic [2:0]  sync_q [SYNC_STAGES];
  logic        irq_s, nmi_s, res_s;

  logic        advance, fetch, vector_taken, nmi_edge, any_req;

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '1;
      end
    end else begin
      sync_q[0] <= {nRES, nNMI, nIRQ};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  assign irq_s = sync_q[SYNC_STAGES-1][0];
  assign nmi_s = sync_q[SYNC_STAGES-1][1];
  assign res_s = sync_q[SYNC_STAGES-1][2];

  assign advance      = READY | ~RnW;
  assign fetch        = advance & (state_q == ST_T1);
  assign vector_taken = advance & (state_q == ST_T5) & BRK;
  assign nmi_edge     = nmi_prev_q & ~nmi_s;
  assign any_req      = ~nres_req_q | ~nnmi_req_q | ~nirq_req_q;

  always_comb begin
    state_d = state_q;
    if (advance) begin
      if (CLEAR_T) begin
        state_d = ST_SD1;
      end else if (NEXT_T) begin
        state_d = ST_T0;
      end else begin
        unique case (state_q)
          ST_T0:   state_d = ST_T1;
          ST_T1:   state_d = ST_T2;
          ST_T2:   state_d = ST_T3;
          ST_T3:   state_d = ST_T4;
          ST_T4:   state_d = ST_T5;
          ST_T5:   state_d = ST_SD1;
          ST_SD1:  state_d = ST_SD2;
          ST_SD2:  state_d = ST_T0;
          default: state_d = ST_T0;
        endcase
      end
    end
  end

  always_comb begin
    ir_d       = ir_q;
    hw_int_d   = hw_int_q;
    nmi_prev_d = nmi_s;
    nirq_req_d = ~(~irq_s & ~PSR_I);
    nres_req_d = nres_req_q;
    nnmi_req_d = nnmi_req_q;

    if (fetch) begin
      if (any_req) begin
        ir_d     = BRK_OPCODE;
        hw_int_d = 1'b1;
      end else begin
        ir_d     = DIR;
        hw_int_d = 1'b0;
      end
    end

    if (!res_s) begin
      nres_req_d = 1'b0;
    end else if (vector_taken) begin
      nres_req_d = 1'b1;
    end

    // Reset outranks NMI in the vector cycle; a fresh edge in that cycle is never lost
    if (nmi_edge) begin
      nnmi_req_d = 1'b0;
    end else if (vector_taken && nres_req_q) begin
      nnmi_req_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_T1;
      ir_q       <= BRK_OPCODE;
      hw_int_q   <= 1'b1;
      nres_req_q <= 1'b0;
      nnmi_req_q <= 1'b1;
      nirq_req_q <= 1'b1;
      nmi_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      ir_q       <= ir_d;
      hw_int_q   <= hw_int_d;
      nres_req_q <= nres_req_d;
      nnmi_req_q <= nnmi_req_d;
      nirq_req_q <= nirq_req_d;
      nmi_prev_q <= nmi_prev_d;
    end
  end

  always_comb begin
    T_state = '0;
    SD2     = 1'b0;
    unique case (state_q)
      ST_T0:   T_state = 6'b000001;
      ST_T1:   T_state = 6'b000010;
      ST_T2:   T_state = 6'b000100;
      ST_T3:   T_state = 6'b001000;
      ST_T4:   T_state = 6'b010000;
      ST_T5:   T_state = 6'b100000;
      ST_SD1:  SD2     = 1'b0;
      ST_SD2:  SD2     = 1'b1;
      default: T_state = '0;
    endcase
  end

  assign IR         = ir_q;
  assign HW_INT     = hw_int_q;
  assign nNMI_req   = nnmi_req_q;
  assign nIRQ_req   = nirq_req_q;
  assign nRESET_req = nres_req_q;
  assign SYNC       = T_state[1];

endmodule

// File: tb/tb_mos6502_timing.sv
// Directed-vector bench for mos6502_timing: one record per clock holding the inputs
// and the expected registered outputs after that clock edge.
module tb_mos6502_timing;

  logic       clk = 1'b0;
  logic       reset, READY, RnW, NEXT_T, CLEAR_T, BRK, PSR_I, nIRQ, nNMI, nRES;
  logic [7:0] DIR;
  logic [5:0] T_state;
  logic       SD2, nNMI_req, nIRQ_req, nRESET_req, HW_INT, SYNC;
  logic [7:0] IR;

  int unsigned nvec = 0;
  int unsigned nmis = 0;

  always #5 clk = ~clk;

  mos6502_timing #(.SYNC_STAGES(2), .BRK_OPCODE(8'h00)) dut (
    .clk(clk), .reset(reset), .READY(READY), .RnW(RnW), .NEXT_T(NEXT_T),
    .CLEAR_T(CLEAR_T), .BRK(BRK), .PSR_I(PSR_I), .nIRQ(nIRQ), .nNMI(nNMI),
    .nRES(nRES), .DIR(DIR), .T_state(T_state), .SD2(SD2), .IR(IR),
    .nNMI_req(nNMI_req), .nIRQ_req(nIRQ_req), .nRESET_req(nRESET_req),
    .HW_INT(HW_INT), .SYNC(SYNC)
  );

  typedef struct {
    string      name;
    bit         rst, rdy, rnw, nxt, clr, brk, psri, nirq, nnmi, nres;
    logic [7:0] dir;
    logic [5:0] t;
    bit         sd2;
    logic [7:0] ir;
    bit         nnr, nir, nrr, hw;
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input string nm, input logic [5:0] t, input bit sd2,
                              input logic [7:0] ir, input bit nnr, input bit nir,
                              input bit nrr, input bit hw,
                              input logic [7:0] dir = 8'hEA, input bit rst = 1'b0,
                              input bit rdy = 1'b1, input bit rnw = 1'b1,
                              input bit nxt = 1'b0, input bit clr = 1'b0,
                              input bit brk = 1'b0, input bit psri = 1'b1,
                              input bit nirq = 1'b1, input bit nnmi = 1'b1,
                              input bit nres = 1'b1);
    vec_t v;
    v.name = nm; v.t = t; v.sd2 = sd2; v.ir = ir;
    v.nnr = nnr; v.nir = nir; v.nrr = nrr; v.hw = hw;
    v.dir = dir; v.rst = rst; v.rdy = rdy; v.rnw = rnw; v.nxt = nxt; v.clr = clr;
    v.brk = brk; v.psri = psri; v.nirq = nirq; v.nnmi = nnmi; v.nres = nres;
    return v;
  endfunction

  // Drive at the falling edge, check 1 time unit after the rising edge
  task automatic apply(input vec_t v);
    bit bad;
    reset = v.rst; READY = v.rdy; RnW = v.rnw; NEXT_T = v.nxt; CLEAR_T = v.clr;
    BRK = v.brk; PSR_I = v.psri; nIRQ = v.nirq; nNMI = v.nnmi; nRES = v.nres;
    DIR = v.dir;
    @(posedge clk);
    #1;
    nvec++;
    bad = (T_state !== v.t) || (IR !== v.ir) || (nNMI_req !== v.nnr) ||
          (nIRQ_req !== v.nir) || (nRESET_req !== v.nrr) || (HW_INT !== v.hw) ||
          (SYNC !== v.t[1]) || ((v.t == 6'b0) && (SD2 !== v.sd2));
    if (bad) begin
      nmis++;
      $display("FAIL %s: got T=%b SD2=%b IR=%h nNMI_req=%b nIRQ_req=%b nRESET_req=%b HW_INT=%b SYNC=%b; want T=%b SD2=%b IR=%h nNMI_req=%b nIRQ_req=%b nRESET_req=%b HW_INT=%b SYNC=%b",
               v.name, T_state, SD2, IR, nNMI_req, nIRQ_req, nRESET_req, HW_INT, SYNC,
               v.t, v.sd2, v.ir, v.nnr, v.nir, v.nrr, v.hw, v.t[1]);
    end
    @(negedge clk);
  endtask

  initial begin
    // Reset, forced BRK fetch, reset vector, then a real fetch
    vq.push_back(mk("reset",          6'b000010, 0, 8'h00, 1, 1, 0, 1, .rst(1)));
    vq.push_back(mk("t1_next_t",      6'b000001, 0, 8'h00, 1, 1, 0, 1, .nxt(1)));
    vq.push_back(mk("t0_to_t1",       6'b000010, 0, 8'h00, 1, 1, 0, 1));
    vq.push_back(mk("reset_fetch_brk",6'b000100, 0, 8'h00, 1, 1, 0, 1));
    vq.push_back(mk("rst_brk_t3",     6'b001000, 0, 8'h00, 1, 1, 0, 1, .brk(1)));
    vq.push_back(mk("rst_brk_t4",     6'b010000, 0, 8'h00, 1, 1, 0, 1, .brk(1)));
    vq.push_back(mk("rst_brk_t5",     6'b100000, 0, 8'h00, 1, 1, 0, 1, .brk(1)));
    vq.push_back(mk("rst_vector_sd1", 6'b000000, 0, 8'h00, 1, 1, 1, 1, .brk(1)));
    vq.push_back(mk("rst_sd2",        6'b000000, 1, 8'h00, 1, 1, 1, 1));
    vq.push_back(mk("rst_t0",         6'b000001, 0, 8'h00, 1, 1, 1, 1));
    vq.push_back(mk("rst_t1",         6'b000010, 0, 8'h00, 1, 1, 1, 1));
    vq.push_back(mk("fetch_dir_ea",   6'b000100, 0, 8'hEA, 1, 1, 1, 0));
    // NMI pulse during an absolute-mode instruction
    vq.push_back(mk("nmi_pin_lo_1",   6'b001000, 0, 8'hEA, 1, 1, 1, 0, .nnmi(0)));
    vq.push_back(mk("nmi_pin_lo_2",   6'b000001, 0, 8'hEA, 1, 1, 1, 0, .nnmi(0), .nxt(1)));
    vq.push_back(mk("nmi_req_set",    6'b000010, 0, 8'hEA, 0, 1, 1, 0, .nnmi(0)));
    vq.push_back(mk("nmi_fetch_brk",  6'b000100, 0, 8'h00, 0, 1, 1, 1));
    vq.push_back(mk("nmi_t3",         6'b001000, 0, 8'h00, 0, 1, 1, 1, .brk(1)));
    vq.push_back(mk("nmi_t4",         6'b010000, 0, 8'h00, 0, 1, 1, 1, .brk(1)));
    vq.push_back(mk("nmi_t5",         6'b100000, 0, 8'h00, 0, 1, 1, 1, .brk(1)));
    vq.push_back(mk("nmi_vector_clr", 6'b000000, 0, 8'h00, 1, 1, 1, 1, .brk(1)));
    vq.push_back(mk("nmi_sd2",        6'b000000, 1, 8'h00, 1, 1, 1, 1));
    vq.push_back(mk("nmi_t0",         6'b000001, 0, 8'h00, 1, 1, 1, 1));
    vq.push_back(mk("nmi_t1",         6'b000010, 0, 8'h00, 1, 1, 1, 1));
    // Second edge re-arms; pin then held low for the whole service
    vq.push_back(mk("fetch_a9",       6'b000100, 0, 8'hA9, 1, 1, 1, 0, .dir(8'hA9), .nnmi(0)));
    vq.push_back(mk("rearm_t3",       6'b001000, 0, 8'hA9, 1, 1, 1, 0, .nnmi(0)));
    vq.push_back(mk("nmi_rearm",      6'b000001, 0, 8'hA9, 0, 1, 1, 0, .nnmi(0), .nxt(1)));
    vq.push_back(mk("rearm_t1",       6'b000010, 0, 8'hA9, 0, 1, 1, 0, .nnmi(0)));
    vq.push_back(mk("nmi2_fetch_brk", 6'b000100, 0, 8'h00, 0, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("nmi2_t3",        6'b001000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("nmi2_t4",        6'b010000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("nmi2_t5",        6'b100000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("nmi2_clr_held",  6'b000000, 0, 8'h00, 1, 1, 1, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("nmi2_sd2",       6'b000000, 1, 8'h00, 1, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("nmi2_t0",        6'b000001, 0, 8'h00, 1, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("nmi2_t1",        6'b000010, 0, 8'h00, 1, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("held_low_once",  6'b000100, 0, 8'hEA, 1, 1, 1, 0, .nnmi(0)));
    // IRQ masked, then unmasked, then released through the synchroniser
    vq.push_back(mk("irq_masked_1",   6'b000001, 0, 8'hEA, 1, 1, 1, 0, .nirq(0), .nxt(1)));
    vq.push_back(mk("irq_masked_2",   6'b000010, 0, 8'hEA, 1, 1, 1, 0, .nirq(0)));
    vq.push_back(mk("irq_masked_ftch",6'b000100, 0, 8'h58, 1, 1, 1, 0, .nirq(0), .dir(8'h58)));
    vq.push_back(mk("irq_unmask",     6'b000001, 0, 8'h58, 1, 0, 1, 0, .nirq(0), .psri(0), .nxt(1)));
    vq.push_back(mk("irq_t1",         6'b000010, 0, 8'h58, 1, 0, 1, 0, .nirq(0), .psri(0)));
    vq.push_back(mk("irq_fetch_brk",  6'b000100, 0, 8'h00, 1, 0, 1, 1, .nirq(0), .psri(0)));
    vq.push_back(mk("irq_release_1",  6'b001000, 0, 8'h00, 1, 0, 1, 1, .psri(0), .brk(1)));
    vq.push_back(mk("irq_release_2",  6'b010000, 0, 8'h00, 1, 0, 1, 1, .psri(0), .brk(1)));
    vq.push_back(mk("irq_release_3",  6'b100000, 0, 8'h00, 1, 1, 1, 1, .psri(0), .brk(1)));
    vq.push_back(mk("irq_sd1",        6'b000000, 0, 8'h00, 1, 1, 1, 1, .brk(1)));
    vq.push_back(mk("irq_sd2",        6'b000000, 1, 8'h00, 1, 1, 1, 1));
    vq.push_back(mk("irq_t0",         6'b000001, 0, 8'h00, 1, 1, 1, 1));
    vq.push_back(mk("irq_t1",         6'b000010, 0, 8'h00, 1, 1, 1, 1));
    // READY stalls reads only
    vq.push_back(mk("fetch_ea",       6'b000100, 0, 8'hEA, 1, 1, 1, 0));
    for (int i = 0; i < 4; i++)
      vq.push_back(mk("stall_read",   6'b000100, 0, 8'hEA, 1, 1, 1, 0, .rdy(0), .dir(8'h11)));
    vq.push_back(mk("stall_release",  6'b001000, 0, 8'hEA, 1, 1, 1, 0));
    vq.push_back(mk("write_no_stall", 6'b010000, 0, 8'hEA, 1, 1, 1, 0, .rdy(0), .rnw(0)));
    vq.push_back(mk("stall_t4",       6'b010000, 0, 8'hEA, 1, 1, 1, 0, .rdy(0)));
    // RMW: CLEAR_T beats NEXT_T
    vq.push_back(mk("rmw_t0",         6'b000001, 0, 8'hEA, 1, 1, 1, 0, .nxt(1)));
    vq.push_back(mk("rmw_t1",         6'b000010, 0, 8'hEA, 1, 1, 1, 0));
    vq.push_back(mk("fetch_ee",       6'b000100, 0, 8'hEE, 1, 1, 1, 0, .dir(8'hEE)));
    vq.push_back(mk("rmw_t3",         6'b001000, 0, 8'hEE, 1, 1, 1, 0));
    vq.push_back(mk("clear_t_prio",   6'b000000, 0, 8'hEE, 1, 1, 1, 0, .clr(1), .nxt(1)));
    vq.push_back(mk("rmw_sd2",        6'b000000, 1, 8'hEE, 1, 1, 1, 0));
    vq.push_back(mk("rmw_sd2_t0",     6'b000001, 0, 8'hEE, 1, 1, 1, 0));
    vq.push_back(mk("rmw_t1b",        6'b000010, 0, 8'hEE, 1, 1, 1, 0));
    // nRES and NMI edge together: reset serviced first, NMI still pending afterwards
    vq.push_back(mk("res_nmi_fetch",  6'b000100, 0, 8'hEA, 1, 1, 1, 0, .nres(0), .nnmi(0)));
    vq.push_back(mk("res_nmi_t3",     6'b001000, 0, 8'hEA, 1, 1, 1, 0, .nres(0), .nnmi(0)));
    vq.push_back(mk("res_nmi_same",   6'b000001, 0, 8'hEA, 0, 1, 0, 0, .nres(0), .nnmi(0), .nxt(1)));
    vq.push_back(mk("res_nmi_t1",     6'b000010, 0, 8'hEA, 0, 1, 0, 0, .nnmi(0)));
    vq.push_back(mk("res_fetch_brk",  6'b000100, 0, 8'h00, 0, 1, 0, 1, .nnmi(0)));
    vq.push_back(mk("res_t3",         6'b001000, 0, 8'h00, 0, 1, 0, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("res_t4",         6'b010000, 0, 8'h00, 0, 1, 0, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("res_t5",         6'b100000, 0, 8'h00, 0, 1, 0, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("res_vector_only",6'b000000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("res_sd2",        6'b000000, 1, 8'h00, 0, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("res_t0",         6'b000001, 0, 8'h00, 0, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("res_t1b",        6'b000010, 0, 8'h00, 0, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("second_brk_nmi", 6'b000100, 0, 8'h00, 0, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("snd_t3",         6'b001000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("snd_t4",         6'b010000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("snd_t5",         6'b100000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("nmi_after_res",  6'b000000, 0, 8'h00, 1, 1, 1, 1, .brk(1), .nnmi(0)));
    vq.push_back(mk("snd_sd2",        6'b000000, 1, 8'h00, 1, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("snd_t0",         6'b000001, 0, 8'h00, 1, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("snd_t1",         6'b000010, 0, 8'h00, 1, 1, 1, 1, .nnmi(0)));
    vq.push_back(mk("fetch_after_nmi",6'b000100, 0, 8'hEA, 1, 1, 1, 0, .nnmi(0)));

    foreach (vq[i]) apply(vq[i]);

    // Reset asserted mid-instruction aborts straight to T1 with a forced BRK
    apply(mk("mid_t3",          6'b001000, 0, 8'hEA, 1, 1, 1, 0));
    apply(mk("mid_reset_abort", 6'b000010, 0, 8'h00, 1, 1, 0, 1, .rst(1)));
    apply(mk("abort_fetch",     6'b000100, 0, 8'h00, 1, 1, 0, 1));
    apply(mk("abort_t3",        6'b001000, 0, 8'h00, 1, 1, 0, 1, .brk(1)));
    apply(mk("abort_t4",        6'b010000, 0, 8'h00, 1, 1, 0, 1, .brk(1)));
    apply(mk("abort_t5",        6'b100000, 0, 8'h00, 1, 1, 0, 1, .brk(1)));
    apply(mk("abort_vector",    6'b000000, 0, 8'h00, 1, 1, 1, 1, .brk(1)));

    // New NMI edge landing on the vector cycle keeps the request pending
    apply(mk("ew_pin_lo_1",     6'b000000, 1, 8'h00, 1, 1, 1, 1, .nnmi(0)));
    apply(mk("ew_pin_lo_2",     6'b000001, 0, 8'h00, 1, 1, 1, 1, .nnmi(0)));
    apply(mk("ew_req_set",      6'b000010, 0, 8'h00, 0, 1, 1, 1));
    apply(mk("ew_fetch_brk",    6'b000100, 0, 8'h00, 0, 1, 1, 1));
    apply(mk("ew_t3",           6'b001000, 0, 8'h00, 0, 1, 1, 1, .brk(1)));
    apply(mk("ew_t4",           6'b010000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    apply(mk("ew_t5",           6'b100000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    apply(mk("edge_beats_clear",6'b000000, 0, 8'h00, 0, 1, 1, 1, .brk(1), .nnmi(0)));
    apply(mk("ew_sd2",          6'b000000, 1, 8'h00, 0, 1, 1, 1));
    apply(mk("ew_t0",           6'b000001, 0, 8'h00, 0, 1, 1, 1));
    apply(mk("ew_t1",           6'b000010, 0, 8'h00, 0, 1, 1, 1));
    apply(mk("third_nmi_brk",   6'b000100, 0, 8'h00, 0, 1, 1, 1));

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
    $finish;
  end

endmodule
